// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the async FIFO write-side control logic.
package fifo_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first valid request after last_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  // Scan from the farthest offset down to the nearest so the nearest valid index wins.
  always_comb begin
    int unsigned idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler: grants one producer at a time for a bounded
// burst into the async FIFO write side, honouring fifo_full.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                          wr_clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic [ID_W-1:0]  grant_nxt;
  logic [ID_W-1:0]  last_ptr, ptr_nxt;
  logic [ID_W-1:0]  winner;
  logic             any_valid;
  logic             xfer;
  logic             g_valid;
  logic             g_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_valid (req_valid),
    .last_ptr  (last_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // State, burst counter, grant and round-robin pointer registers.
  always_ff @(posedge wr_clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      grant_id  <= '0;
      last_ptr  <= ID_W'(NUM_REQ - 1);
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      grant_id  <= grant_nxt;
      last_ptr  <= ptr_nxt;
    end
  end

  // Next-state and output muxing; burst outputs are also masked while reset_n is low.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = burst_cnt;
    grant_nxt  = grant_id;
    ptr_nxt    = last_ptr;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    busy       = 1'b0;
    xfer       = 1'b0;
    g_valid    = req_valid[grant_id];
    g_last     = req_last[grant_id];

    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          state_nxt = ST_BURST;
          grant_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        if (reset_n) begin
          busy                = 1'b1;
          req_ready[grant_id] = !fifo_full;
          xfer                = g_valid && !fifo_full;
          fifo_wr_en          = xfer;
          if (xfer) begin
            fifo_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (xfer) begin
          cnt_nxt = burst_cnt + CNT_W'(1);
        end
        if (!g_valid
            || (xfer && (burst_cnt == CNT_W'(MAX_BURST - 1)))
            || (xfer && g_last)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = grant_id;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MB = 4;
  localparam int CW = 3;

  logic             wr_clk;
  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data;
  logic [IW-1:0]    grant_id;
  logic             busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_W       (IW),
    .MAX_BURST  (MB),
    .CNT_W      (CW)
  ) dut (
    .wr_clk     (wr_clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: burst budget in words, rotating top-priority index.
  bit m_busy;
  int m_g;
  int m_left;
  int m_prio;
  int wr_count;

  // Producer side: current word state and sequence numbers.
  bit cv[NR];
  bit cl[NR];
  int seq[NR];
  int wr_seq[NR];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_g    = 0;
    m_left = 0;
    m_prio = 0;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model and producers.
  task automatic step(input int mask, input int pv, input int pl, input int pf,
                      input int pd, input bit rst);
    logic [NR-1:0] e_rdy;
    logic          e_wr;
    logic [DW-1:0] e_data;
    logic          e_busy;
    int            old_g;
    bit            acc;
    @(negedge wr_clk);
    reset_n   = !rst;
    fifo_full = ($urandom_range(99) < pf);
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = cv[i];
      req_last[i]           = cl[i];
      req_data[i*DW +: DW]  = {4'(i), 12'(seq[i])};
    end
    #1;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    e_busy = 1'b0;
    if (reset_n && m_busy) begin
      e_busy = 1'b1;
      if (!fifo_full) e_rdy[m_g] = 1'b1;
      e_wr = cv[m_g] && !fifo_full;
      if (e_wr) e_data = {4'(m_g), 12'(seq[m_g])};
    end
    check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
    check_eq("wr_en", 32'(fifo_wr_en), 32'(e_wr));
    check_eq("data", 32'(fifo_data), 32'(e_data));
    check_eq("grant", 32'(grant_id), 32'(m_g));
    check_eq("busy", 32'(busy), 32'(e_busy));
    if (e_wr) begin
      check_eq("order", 32'(fifo_data), 32'({4'(m_g), 12'(wr_seq[m_g])}));
      wr_seq[m_g]++;
      wr_count++;
    end

    old_g = m_g;
    if (!reset_n) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = NR - 1; k >= 0; k--) begin
        if (cv[(m_prio + k) % NR]) begin
          m_g    = (m_prio + k) % NR;
          m_busy = 1'b1;
        end
      end
      m_left = MB;
    end else begin
      if (e_wr) m_left--;
      if (!cv[m_g] || (e_wr && (m_left == 0 || cl[m_g]))) begin
        m_busy = 1'b0;
        m_prio = (m_g + 1) % NR;
      end
    end

    for (int i = 0; i < NR; i++) begin
      acc = e_wr && (i == old_g);
      if (acc) seq[i]++;
      if (cv[i] && !acc) begin
        if ($urandom_range(99) < pd) cv[i] = 1'b0;
      end else begin
        cv[i] = mask[i] && ($urandom_range(99) < pv);
        cl[i] = ($urandom_range(99) < pl);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wr_count  = 0;
    for (int i = 0; i < NR; i++) begin
      cv[i] = 1'b0; cl[i] = 1'b0; seq[i] = 0; wr_seq[i] = 0;
    end
    repeat (2) @(posedge wr_clk);
    model_reset();

    // Reset state while held in reset.
    step(4'hF, 0, 0, 0, 0, 1'b1);

    // Full contention from IDLE: 20 writes in 25 cycles.
    for (int i = 0; i < NR; i++) begin cv[i] = 1'b1; cl[i] = 1'b0; end
    wr_count = 0;
    repeat (25) step(4'hF, 100, 0, 0, 0, 1'b0);
    check_eq("throughput", 32'(wr_count), 32'd20);

    // General random traffic.
    repeat (300) step(4'hF, 60, 20, 20, 10, 1'b0);

    // Reset mid-burst, two edges, then traffic resumes.
    for (int n = 0; n < 50 && !m_busy; n++) step(4'hF, 100, 0, 0, 0, 1'b0);
    check_eq("burst_before_reset", 32'(m_busy), 32'd1);
    step(4'hF, 100, 0, 0, 0, 1'b1);
    step(4'hF, 100, 0, 0, 0, 1'b1);
    repeat (100) step(4'hF, 100, 0, 10, 0, 1'b0);

    // Single producer streams, long bursts.
    repeat (100) step(4'h2, 100, 0, 0, 0, 1'b0);
    repeat (100) step(4'h1, 90, 5, 0, 0, 1'b0);

    // Heavy back-pressure with drops during stalls.
    repeat (200) step(4'hF, 80, 10, 70, 15, 1'b0);

    // Every word is a packet end.
    repeat (150) step(4'hF, 70, 100, 15, 5, 1'b0);

    // Sparse requests with frequent valid drops.
    repeat (200) step(4'hC, 40, 10, 20, 40, 1'b0);

    // Mixed, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      step(4'hF, 65, 25, 25, 10, ($urandom_range(99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
